// File: rtl/lda_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module      : lda_pixel_sink
// Description : Pixel sink for a line-drawing engine. In-range pixels are
//               queued in a small FIFO, converted to a linear framebuffer word
//               address (y*SCREEN_W + x) and written through a registered
//               valid/ready write port. Off-screen pixels are discarded and
//               counted. A clear request fills the whole screen with a
//               latched colour once all earlier pixels have been written.
//
// Ports       : i_clk, i_reset        clock, asynchronous active-high reset
//               i_px_valid/o_px_ready pixel handshake (i_px_x, i_px_y,
//                                     i_px_color carry the pixel)
//               i_clear, i_clear_color single-cycle clear-screen request
//               o_mem_we/o_mem_addr/o_mem_data/i_mem_ready
//                                     framebuffer write port
//               o_busy                work pending or in progress
//               o_drop_count          saturating count of off-screen pixels
//
// Revision    : 1.0 - initial release
// ============================================================================
module lda_pixel_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_px_valid,
    output logic        o_px_ready,
    input  logic [8:0]  i_px_x,
    input  logic [7:0]  i_px_y,
    input  logic        i_px_color,
    input  logic        i_clear,
    input  logic        i_clear_color,
    output logic        o_mem_we,
    output logic [16:0] o_mem_addr,
    output logic        o_mem_data,
    input  logic        i_mem_ready,
    output logic        o_busy,
    output logic [7:0]  o_drop_count
);

    localparam int              c_AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_FIFO_FULL = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]      c_SCREEN_W  = 10'(SCREEN_W);
    localparam logic [8:0]      c_SCREEN_H  = 9'(SCREEN_H);
    localparam logic [16:0]     c_LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

    localparam logic [0:0]      c_ST_RUN    = 1'b0;
    localparam logic [0:0]      c_ST_CLEAR  = 1'b1;

    // FIFO storage: {x[8:0], y[7:0], color}
    logic [17:0]     r_fifo [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic [0:0]      r_state;
    logic            r_clear_pending;
    logic            r_clear_color;
    logic            r_mem_we;
    logic [16:0]     r_mem_addr;
    logic            r_mem_data;
    logic [7:0]      r_drop_count;

    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_px_ready;
    logic            w_px_fire;
    logic            w_px_in_range;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_retire;
    logic            w_out_free;
    logic            w_start_clear;
    logic [17:0]     w_head;
    logic [8:0]      w_head_x;
    logic [7:0]      w_head_y;
    logic            w_head_color;
    logic [16:0]     w_head_addr;

    assign w_fifo_empty  = (r_count == '0);
    assign w_fifo_full   = (r_count == c_FIFO_FULL);

    // Ready depends on registered state only, never on i_px_valid.
    assign w_px_ready    = !w_fifo_full && !r_clear_pending && (r_state == c_ST_RUN);
    assign w_px_fire     = i_px_valid && w_px_ready;
    assign w_px_in_range = ({1'b0, i_px_x} < c_SCREEN_W) && ({1'b0, i_px_y} < c_SCREEN_H);
    assign w_push        = w_px_fire && w_px_in_range;
    assign w_drop        = w_px_fire && !w_px_in_range;

    // The output register can take new data when it is empty or its current
    // write completes on this edge.
    assign w_retire      = r_mem_we && i_mem_ready;
    assign w_out_free    = !r_mem_we || i_mem_ready;

    // Clear only starts once every earlier pixel has left the FIFO and the
    // output register; this keeps pixel writes ahead of clear writes.
    assign w_start_clear = (r_state == c_ST_RUN) && r_clear_pending && w_fifo_empty && w_out_free;
    assign w_pop         = (r_state == c_ST_RUN) && w_out_free && !w_fifo_empty;

    assign w_head        = r_fifo[r_rd_ptr];
    assign w_head_x      = w_head[17:9];
    assign w_head_y      = w_head[8:1];
    assign w_head_color  = w_head[0];

    generate
        if (SCREEN_W == 320) begin : g_addr_320
            // y*320 = y*256 + y*64
            assign w_head_addr = ({9'b0, w_head_y} << 8) + ({9'b0, w_head_y} << 6)
                               + {8'b0, w_head_x};
        end else begin : g_addr_generic
            assign w_head_addr = ({9'b0, w_head_y} * 17'(SCREEN_W)) + {8'b0, w_head_x};
        end
    endgenerate

    // FIFO payload storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {i_px_x, i_px_y, i_px_color};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= c_ST_RUN;
            r_clear_pending <= 1'b0;
            r_clear_color   <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_data      <= 1'b0;
        end else begin
            if (i_clear && (r_state == c_ST_RUN) && !r_clear_pending) begin
                r_clear_pending <= 1'b1;
                r_clear_color   <= i_clear_color;
            end

            case (r_state)
                c_ST_RUN: begin
                    if (w_start_clear) begin
                        r_state         <= c_ST_CLEAR;
                        r_clear_pending <= 1'b0;
                        r_mem_we        <= 1'b1;
                        r_mem_addr      <= '0;
                        r_mem_data      <= r_clear_color;
                    end else if (w_pop) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_head_addr;
                        r_mem_data <= w_head_color;
                    end else if (w_retire) begin
                        r_mem_we <= 1'b0;
                    end
                end
                c_ST_CLEAR: begin
                    // The write address doubles as the clear counter.
                    if (w_retire) begin
                        if (r_mem_addr == c_LAST_ADDR) begin
                            r_mem_we <= 1'b0;
                            r_state  <= c_ST_RUN;
                        end else begin
                            r_mem_addr <= r_mem_addr + 17'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                end
            endcase
        end
    end

    assign o_px_ready   = w_px_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_drop_count = r_drop_count;
    assign o_busy       = !w_fifo_empty || r_mem_we || r_clear_pending || (r_state == c_ST_CLEAR);

endmodule
`default_nettype wire

// File: doc/lda_pixel_sink.md
LDA_PIXEL_SINK -- requirements
Module: lda_pixel_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SCREEN_W, default 320, visible columns.
REQ-003 SHALL have parameter SCREEN_H, default 240, visible rows.
REQ-004 i_clk  input  1  clock; all state on rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_px_valid  input  1  pixel request from the line-drawing engine.
REQ-007 o_px_ready  output  1  sink can accept a pixel this cycle.
REQ-008 i_px_x  input  9  pixel column.
REQ-009 i_px_y  input  8  pixel row.
REQ-010 i_px_color  input  1  pixel colour.
REQ-011 i_clear  input  1  single-cycle clear-screen request.
REQ-012 i_clear_color  input  1  fill colour, sampled with i_clear.
REQ-013 o_mem_we  output  1  framebuffer write valid.
REQ-014 o_mem_addr  output  17  framebuffer word address.
REQ-015 o_mem_data  output  1  framebuffer write data.
REQ-016 i_mem_ready  input  1  framebuffer accepts the write this cycle.
REQ-017 o_busy  output  1  work pending or in progress.
REQ-018 o_drop_count  output  8  count of discarded off-screen pixels.

Function
REQ-019 Pixel handshake: pixel transfers on rising edge with i_px_valid && o_px_ready; o_px_ready = !fifo_full && !clear_pending && state==RUN (registered state only, no combinational path from i_px_valid).
REQ-020 Accepted pixel with x >= SCREEN_W or y >= SCREEN_H: consumed, not enqueued, o_drop_count +1 saturating at 255.
REQ-021 In-range pixel enqueued as {x, y, color}; FIFO strictly in order; push and pop in same cycle allowed when not full.
REQ-022 Address = y*SCREEN_W + x, computed from FIFO head with shifts/adds (y<<8 + y<<6 + x for defaults), 17-bit result.
REQ-023 Output stage: o_mem_we/o_mem_addr/o_mem_data are registers; a write is held stable while o_mem_we && !i_mem_ready; it retires on an edge with o_mem_we && i_mem_ready.
REQ-024 Output register loads FIFO head (and pops) on an edge where it is empty or retiring and FIFO is non-empty; otherwise o_mem_we clears on retire.
REQ-025 Latency: pixel accepted at edge N into empty sink -> o_mem_we=1 with its address after edge N+1; sustained throughput one write per cycle with i_mem_ready held high.
REQ-026 FSM states RUN, CLEAR; clear_pending flag set when i_clear sampled in RUN, latching i_clear_color; i_clear ignored while clear_pending or in CLEAR.
REQ-027 RUN -> CLEAR when clear_pending, FIFO empty and output register empty or retiring; clear_pending drops on the transition.
REQ-028 CLEAR: writes addresses 0 to SCREEN_W*SCREEN_H-1 ascending, data = latched clear colour, each advancing only on retire; after retire of last address (76799 default) -> RUN.
REQ-029 Pixels accepted before i_clear are written before any clear write; o_px_ready low from the edge sampling i_clear until return to RUN.
REQ-030 o_busy = FIFO non-empty || o_mem_we || clear_pending || state==CLEAR.
REQ-031 i_px_x/i_px_y/i_px_color ignored when no transfer occurs.

Reset
REQ-032 On i_reset: FIFO emptied, state RUN, clear_pending 0, clear counter 0, o_mem_we 0, o_mem_addr 0, o_mem_data 0, o_drop_count 0, o_busy 0; o_px_ready 1 once deasserted.
REQ-033 Reset during CLEAR or with writes pending aborts them; no further writes after reset asserts.

Verification
REQ-034 Single pixel (x=5,y=3,c=1), i_mem_ready=1 -> one write addr 965 data 1, o_mem_we high exactly one cycle, two edges after acceptance.
REQ-035 Push 6 pixels back-to-back, i_mem_ready=0 -> o_px_ready drops after 5 accepted (4 FIFO + 1 output); release ready -> all 6 written in order, no loss/dup.
REQ-036 Pixels (320,0), (0,240), (319,239) -> one write at addr 76799; o_drop_count = 2; 300 off-screen pixels -> count holds 255.
REQ-037 3 pixels queued, then i_clear with colour 0 -> 3 pixel writes first, then 76800 writes addr 0..76799 data 0, o_px_ready low throughout, o_busy low after last.
REQ-038 i_mem_ready toggling randomly during CLEAR -> address/data stable while stalled, no address skipped.
REQ-039 Assert i_reset mid-CLEAR at addr 1000 -> o_mem_we 0 immediately, o_busy 0, next pixel after release written normally.
